dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_arbiter_rr_arb2.sv | 24 ++
 rtl/dm_arbiter.sv | 158 +++++++++++++++
 tb/tb_dm_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// dm_pkg : shared state encoding, default depth and word-index width helper
// Rev 1.0
// ============================================================================
package dm_pkg;

    localparam int unsigned DM_DEPTH = 3072;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dm_state_e;

    function automatic int unsigned dm_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned DM_IDX_W = dm_idx_w(DM_DEPTH);

endpackage
`default_nettype wire

// File: rtl/dm_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, one-hot grant
// Rev 1.0
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // last_i is the index of the most recent winner; a tie goes to the other one
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// dm_arbiter : two-port data-memory arbiter with hardware memory clear
// Rev 1.0
// ============================================================================
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH        = DM_DEPTH,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic [31:0] m0_pc,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [31:0] m1_pc,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic        m1_err,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rd,

    input  logic        clr_start,
    output logic        clr_busy,
    output logic        clr_done
);

    localparam int unsigned      IDX_W    = dm_idx_w(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    dm_state_e        state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             pend_q;
    logic             done_q;
    logic             last_q, last_d;
    logic [1:0]       rvalid_q;
    logic [1:0]       err_q;
    logic [31:0]      rdata0_q, rdata1_q;

    logic [1:0]       req_w;
    logic [1:0]       gnt_w;
    logic             err0_w, err1_w;

    assign err0_w = (m0_addr[1:0] != 2'b00) || (m0_addr[31:2] >= 30'(DEPTH));
    assign err1_w = (m1_addr[1:0] != 2'b00) || (m1_addr[31:2] >= 30'(DEPTH));

    // requests are masked while reset is low so nothing reaches the memory
    assign req_w = {m1_req, m0_req} & {2{(state_q == ST_IDLE) && reset}};

    rr_arb2 u_arb (
        .req_i  (req_w),
        .last_i (last_q),
        .gnt_o  (gnt_w)
    );

    assign last_d = (|gnt_w) ? gnt_w[1] : last_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start || pend_q) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = 32'h0;
        mem_wd   = 32'h0;
        mem_pc   = 32'h0;
        if (state_q == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = 32'({cnt_q, 2'b00});
        end else if (gnt_w[0]) begin
            mem_we   = m0_we & ~err0_w;
            mem_addr = m0_addr;
            mem_wd   = m0_wd;
            mem_pc   = m0_pc;
        end else if (gnt_w[1]) begin
            mem_we   = m1_we & ~err1_w;
            mem_addr = m1_addr;
            mem_wd   = m1_wd;
            mem_pc   = m1_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= CLR_ON_RESET;
            done_q   <= 1'b0;
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= 1'b0;
            done_q   <= (state_q == ST_CLEAR) && (cnt_q == LAST_IDX);
            last_q   <= last_d;
            rvalid_q <= gnt_w;
            err_q    <= gnt_w & {err1_w, err0_w};
            rdata0_q <= (gnt_w[0] && !err0_w && !m0_we) ? mem_rd : 32'h0;
            rdata1_q <= (gnt_w[1] && !err1_w && !m1_we) ? mem_rd : 32'h0;
        end
    end

    assign m0_gnt    = gnt_w[0];
    assign m1_gnt    = gnt_w[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign clr_busy  = (state_q == ST_CLEAR);
    assign clr_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dm_arbiter : directed stimulus with scoreboard-checked responses
// Rev 1.0
// ============================================================================
module tb_dm_arbiter;

    localparam int DEPTH = 3072;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m0_pc, m1_addr, m1_wd, m1_pc;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_pc, mem_rd;
    logic        clr_start, clr_busy, clr_done;
    logic        fill_en;

    logic [31:0] mem [0:DEPTH-1];
    rsp_t        q0[$], q1[$];
    rsp_t        e0, e1;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.DEPTH(DEPTH), .CLR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_pc(m0_pc),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_pc(m1_pc),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_pc(mem_pc), .mem_rd(mem_rd),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    // memory model; out-of-range reads return a poison value
    assign mem_rd = (mem_addr[31:2] < 30'(DEPTH)) ? mem[mem_addr[13:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (mem_we && (mem_addr[31:2] < 30'(DEPTH))) begin
            mem[mem_addr[13:2]] <= mem_wd;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m0_rvalid) begin
            if (q0.size() == 0) chk("m0 unexpected rvalid", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("m0 rdata", m0_rdata, e0.rdata);
                chk("m0 err", m0_err, e0.err);
            end
        end else chk("m0 idle response", {m0_rdata, m0_err}, 0);
        if (m1_rvalid) begin
            if (q1.size() == 0) chk("m1 unexpected rvalid", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("m1 rdata", m1_rdata, e1.rdata);
                chk("m1 err", m1_err, e1.err);
            end
        end else chk("m1 idle response", {m1_rdata, m1_err}, 0);
    end

    task automatic drive(input int k, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] pc);
        if (k == 0) begin m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd; m0_pc = pc; end
        else        begin m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd; m1_pc = pc; end
    endtask

    task automatic watch_clear(input string tag);
        int busy = 0, bad = 0, done = 0, guard = 0;
        @(negedge clk); #2;
        while (clr_busy && guard < 2 * DEPTH) begin
            if (mem_we !== 1'b1 || mem_addr !== 32'(busy * 4) || mem_wd !== 0 || mem_pc !== 0
                || m0_gnt || m1_gnt) bad++;
            if (clr_done) done++;
            busy++; guard++;
            @(negedge clk); #2;
        end
        chk({tag, " busy cycles"}, busy, DEPTH);
        chk({tag, " clear sequence"}, bad, 0);
        chk({tag, " early done"}, done, 0);
        chk({tag, " done pulse"}, clr_done, 1);
        @(negedge clk); #2;
        chk({tag, " done single"}, clr_done, 0);
    endtask

    task automatic chk_mem_zero(input string tag);
        int nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'h0) nz++;
        chk({tag, " memory zero"}, nz, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy, bad, guard;
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        clr_start = 1'b0;
        fill_en   = 1'b1;

        // held in reset: request must be ignored
        @(negedge clk); fill_en = 1'b0; #2;
        chk("reset m0_gnt", m0_gnt, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset clr_busy", clr_busy, 0);
        chk("reset clr_done", clr_done, 0);
        m0_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        watch_clear("por");
        chk_mem_zero("por");

        // round-robin with both requesting: m0 first after reset
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("rr grant %0d", i), {m1_gnt, m0_gnt}, (i % 2) ? 2'b10 : 2'b01);
            if (i % 2) q1.push_back('{32'h0, 1'b0}); else q0.push_back('{32'h0, 1'b0});
            @(negedge clk);
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // m0 write then read back
        drive(0, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'h400);
        #2;
        chk("wr gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("wr mem_we", mem_we, 1);
        chk("wr mem_addr", mem_addr, 32'h100);
        chk("wr mem_wd", mem_wd, 32'h1234_5678);
        chk("wr mem_pc", mem_pc, 32'h400);
        q0.push_back('{32'h0, 1'b0});
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
        #2;
        chk("rd gnt", m0_gnt, 1);
        chk("rd mem_we", mem_we, 0);
        q0.push_back('{32'h1234_5678, 1'b0});
        @(negedge clk);
        m0_req = 1'b0;
        #2;
        chk("no-grant mem bus", {mem_we, mem_addr, mem_wd, mem_pc}, 0);

        // m1 write then read, then m0 reads m1's word
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 32'h0);
        #2; chk("m1 wr gnt", m1_gnt, 1); q1.push_back('{32'h0, 1'b0});
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h204, 32'h0, 32'h0);
        #2; chk("m1 rd gnt", m1_gnt, 1); q1.push_back('{32'hCAFE_F00D, 1'b0});
        @(negedge clk);
        m1_req = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h204, 32'h0, 32'h0);
        #2; chk("m0 rd2 gnt", m0_gnt, 1); q0.push_back('{32'hCAFE_F00D, 1'b0});
        @(negedge clk);
        m0_req = 1'b0;

        // error requests: out of range, misaligned, erroneous write; last valid word
        drive(1, 1'b1, 1'b0, 32'h3000, 32'h0, 32'h0);
        #2; chk("err range gnt", m1_gnt, 1); chk("err range we", mem_we, 0);
        q1.push_back('{32'h0, 1'b1});
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0);
        #2; chk("err align gnt", m1_gnt, 1); chk("err align we", mem_we, 0);
        q1.push_back('{32'h0, 1'b1});
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h3000, 32'hFFFF_FFFF, 32'h0);
        #2; chk("err write we", mem_we, 0);
        q1.push_back('{32'h0, 1'b1});
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h2FFC, 32'h0, 32'h0);
        #2; chk("last word gnt", m1_gnt, 1);
        q1.push_back('{32'h0, 1'b0});
        @(negedge clk);
        m1_req = 1'b0;

        // clear started mid-traffic; restart attempt at cnt=10 is ignored
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
        clr_start = 1'b1;
        #2; chk("clr mid gnt", m0_gnt, 1);
        q0.push_back('{32'h1234_5678, 1'b0});
        @(negedge clk);
        clr_start = 1'b0;
        busy = 0; bad = 0; guard = 0;
        #2;
        while (clr_busy && guard < 2 * DEPTH) begin
            if (m0_gnt || m1_gnt || mem_addr !== 32'(busy * 4)) bad++;
            clr_start = (busy == 10);
            busy++; guard++;
            @(negedge clk); #2;
        end
        clr_start = 1'b0;
        chk("clr2 busy cycles", busy, DEPTH);
        chk("clr2 no grant/no restart", bad, 0);
        chk("clr2 first idle gnt", m0_gnt, 1);
        chk("clr2 done", clr_done, 1);
        q0.push_back('{32'h0, 1'b0});
        @(negedge clk);
        m0_req = 1'b0;

        // asynchronous reset at cnt=100, clear restarts from word 0
        fill_en = 1'b1;
        @(negedge clk);
        fill_en = 1'b0; clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        guard = 0;
        #2;
        while (!(clr_busy && mem_addr == 32'd400) && guard < 500) begin
            guard++; @(negedge clk); #2;
        end
        chk("reached cnt 100", guard < 500, 1);
        reset = 1'b0;
        #1;
        chk("async clr_busy", clr_busy, 0);
        chk("async mem bus", {mem_we, mem_addr}, 0);
        bad = 0;
        repeat (3) begin @(negedge clk); #2; if (clr_done) bad++; end
        chk("no done on abort", bad, 0);
        @(negedge clk); reset = 1'b1;
        watch_clear("restart");
        chk_mem_zero("restart");

        repeat (3) @(negedge clk);
        chk("m0 queue drained", q0.size(), 0);
        chk("m1 queue drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
